// File: rtl/udp_ip_axil_pkg.sv
// Shared types and constants for the udp_ip AXI4-Lite control register file.
package udp_ip_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte offsets of the implemented control registers
    localparam logic [7:0] REG_CTRL     = 8'h00;
    localparam logic [7:0] REG_SRC_PORT = 8'h04;
    localparam logic [7:0] REG_DST_PORT = 8'h08;
    localparam logic [7:0] REG_DST_IP   = 8'h0C;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_ADDR,
        WR_HAVE_DATA,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

endpackage

// File: rtl/udp_ip_axil_wstrb_merge.sv
// Byte-lane merge: each lane takes the new byte where its strobe is set,
// otherwise keeps the old byte.
module udp_ip_axil_wstrb_merge #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_data,
    input  logic [DATA_W-1:0]   new_data,
    input  logic [DATA_W/8-1:0] strb,
    output logic [DATA_W-1:0]   merged_data
);

    // Per-byte select between old and new data
    always_comb begin
        merged_data = old_data;
        for (int b = 0; b < DATA_W / 8; b++) begin
            if (strb[b]) begin
                merged_data[8*b +: 8] = new_data[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/udp_ip_axil_regs.sv
// AXI4-Lite slave register file behind the udp_ip S00_AXI port.
//
// Write FSM
//   state        | meaning
//   WR_IDLE      | both AW and W accepted; waiting for either or both
//   WR_HAVE_ADDR | address latched, waiting for write data
//   WR_HAVE_DATA | data/strobe latched, waiting for write address
//   WR_RESP      | commit done, holding BVALID until BREADY
// Read FSM
//   state        | meaning
//   RD_IDLE      | AR accepted
//   RD_RESP      | RDATA/RRESP held until RREADY
module udp_ip_axil_regs
    import udp_ip_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]               wr_pulse
);

    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int AW     = C_S_AXI_ADDR_WIDTH;
    localparam int STRB_W = DW / 8;
    localparam int IDX_W  = AW - 2;

    wr_state_t           wr_state;
    rd_state_t           rd_state;
    logic [AW-1:0]       aw_addr_q;
    logic [DW-1:0]       w_data_q;
    logic [STRB_W-1:0]   w_strb_q;
    logic [DW-1:0]       regs [NUM_REGS];

    logic                cm_fire;
    logic [AW-1:0]       cm_addr;
    logic [DW-1:0]       cm_data;
    logic [STRB_W-1:0]   cm_strb;
    logic [IDX_W-1:0]    cm_idx;
    logic                cm_in_range;
    logic [DW-1:0]       cm_old;
    logic [DW-1:0]       cm_merged;

    logic [IDX_W-1:0]    ar_idx;
    logic                ar_in_range;
    logic [DW-1:0]       ar_val;

    // Address bits below word granularity and the protection fields carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, cm_addr[1:0], S_AXI_ARADDR[1:0]};

    // Commit select: pick live or latched address/data depending on which half arrived first
    always_comb begin
        cm_fire = 1'b0;
        cm_addr = S_AXI_AWADDR;
        cm_data = S_AXI_WDATA;
        cm_strb = S_AXI_WSTRB;
        case (wr_state)
            WR_IDLE: cm_fire = S_AXI_AWVALID && S_AXI_WVALID;
            WR_HAVE_ADDR: begin
                cm_fire = S_AXI_WVALID;
                cm_addr = aw_addr_q;
            end
            WR_HAVE_DATA: begin
                cm_fire = S_AXI_AWVALID;
                cm_data = w_data_q;
                cm_strb = w_strb_q;
            end
            default: cm_fire = 1'b0;
        endcase
    end

    assign cm_idx      = cm_addr[AW-1:2];
    assign cm_in_range = 32'(cm_idx) < 32'(NUM_REGS);
    assign ar_idx      = S_AXI_ARADDR[AW-1:2];
    assign ar_in_range = 32'(ar_idx) < 32'(NUM_REGS);

    // Current contents of the register addressed by the pending write and by the read
    always_comb begin
        cm_old = '0;
        ar_val = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (cm_idx == IDX_W'(k)) cm_old = regs[k];
            if (ar_idx == IDX_W'(k)) ar_val = regs[k];
        end
    end

    udp_ip_axil_wstrb_merge #(
        .DATA_W (DW)
    ) u_merge (
        .old_data    (cm_old),
        .new_data    (cm_data),
        .strb        (cm_strb),
        .merged_data (cm_merged)
    );

    // Write channel FSM, register array and write pulses
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state      <= WR_IDLE;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            wr_pulse      <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else begin
            wr_pulse <= '0;
            if (cm_fire) begin
                wr_state      <= WR_RESP;
                S_AXI_AWREADY <= 1'b0;
                S_AXI_WREADY  <= 1'b0;
                S_AXI_BVALID  <= 1'b1;
                S_AXI_BRESP   <= cm_in_range ? RESP_OKAY : RESP_SLVERR;
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (cm_in_range && cm_idx == IDX_W'(k)) begin
                        regs[k]     <= cm_merged;
                        wr_pulse[k] <= 1'b1;
                    end
                end
            end else begin
                case (wr_state)
                    WR_IDLE: begin
                        if (S_AXI_AWVALID) begin
                            aw_addr_q     <= S_AXI_AWADDR;
                            S_AXI_AWREADY <= 1'b0;
                            wr_state      <= WR_HAVE_ADDR;
                        end else if (S_AXI_WVALID) begin
                            w_data_q     <= S_AXI_WDATA;
                            w_strb_q     <= S_AXI_WSTRB;
                            S_AXI_WREADY <= 1'b0;
                            wr_state     <= WR_HAVE_DATA;
                        end
                    end
                    WR_RESP: begin
                        if (S_AXI_BREADY) begin
                            S_AXI_BVALID  <= 1'b0;
                            S_AXI_AWREADY <= 1'b1;
                            S_AXI_WREADY  <= 1'b1;
                            wr_state      <= WR_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read channel FSM; the register sample happens before any same-edge write lands
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_state      <= RD_IDLE;
            S_AXI_ARREADY <= 1'b1;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (S_AXI_ARVALID) begin
                        S_AXI_RDATA   <= ar_in_range ? ar_val : '0;
                        S_AXI_RRESP   <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_ARREADY <= 1'b0;
                        rd_state      <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID  <= 1'b0;
                        S_AXI_ARREADY <= 1'b1;
                        rd_state      <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
        assign reg_out[DW*k +: DW] = regs[k];
    end

endmodule

// File: tb/tb_udp_ip_axil_regs.sv
// Scoreboard bench for udp_ip_axil_regs: stimulus pushes expected B/R
// responses, a negedge monitor pops and compares on each handshake.
module tb_udp_ip_axil_regs;
    import udp_ip_axil_pkg::*;

    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic [4:0]   S_AXI_AWADDR = '0;
    logic [2:0]   S_AXI_AWPROT = '0;
    logic         S_AXI_AWVALID = 1'b0;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA = '0;
    logic [3:0]   S_AXI_WSTRB = '0;
    logic         S_AXI_WVALID = 1'b0;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY = 1'b1;
    logic [4:0]   S_AXI_ARADDR = '0;
    logic [2:0]   S_AXI_ARPROT = '0;
    logic         S_AXI_ARVALID = 1'b0;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY = 1'b1;
    logic [127:0] reg_out;
    logic [3:0]   wr_pulse;

    always #5 ACLK = ~ACLK;

    udp_ip_axil_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5),
        .NUM_REGS           (4)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .reg_out       (reg_out),
        .wr_pulse      (wr_pulse)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    int          errors = 0;
    int          checks = 0;
    logic [1:0]  exp_b[$];
    rexp_t       exp_r[$];
    int          pulse_cnt[4] = '{0, 0, 0, 0};

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected handshake", name);
    endfunction

    // Monitor: counts write pulses and checks every B/R handshake against the queues
    always @(negedge ACLK) begin : mon
        rexp_t e;
        if (ARESETN) begin
            for (int k = 0; k < 4; k++) pulse_cnt[k] += 32'(wr_pulse[k]);
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                if (exp_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected: got bresp %0h expected no response", S_AXI_BRESP);
                end else begin
                    chk("bresp", 128'(S_AXI_BRESP), 128'(exp_b.pop_front()));
                end
            end
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                if (exp_r.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL r_unexpected: got rdata %0h expected no response", S_AXI_RDATA);
                end else begin
                    e = exp_r.pop_front();
                    chk("rdata", 128'(S_AXI_RDATA), 128'(e.data));
                    chk("rresp", 128'(S_AXI_RRESP), 128'(e.resp));
                end
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] er, input string nm);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit aw_now;
        bit w_now;
        int n = 0;
        exp_b.push_back(er);
        S_AXI_AWADDR  = a[4:0];
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = d;
        S_AXI_WSTRB   = s;
        S_AXI_WVALID  = 1'b1;
        while (!(aw_done && w_done) && n < 40) begin
            @(negedge ACLK);
            aw_now = S_AXI_AWVALID && S_AXI_AWREADY;
            w_now  = S_AXI_WVALID && S_AXI_WREADY;
            tick();
            if (aw_now) begin aw_done = 1'b1; S_AXI_AWVALID = 1'b0; end
            if (w_now)  begin w_done  = 1'b1; S_AXI_WVALID  = 1'b0; end
            n++;
        end
        if (!(aw_done && w_done)) fail_now({nm, "_handshake"});
        else chk({nm, "_bvalid_lat"}, 128'(S_AXI_BVALID), 128'(1'b1));
    endtask

    task automatic axi_read(input logic [7:0] a, input logic [31:0] d, input logic [1:0] er,
                            input string nm);
        rexp_t e;
        bit ar_now = 1'b0;
        int n = 0;
        e.data = d;
        e.resp = er;
        exp_r.push_back(e);
        S_AXI_ARADDR  = a[4:0];
        S_AXI_ARVALID = 1'b1;
        while (!ar_now && n < 40) begin
            @(negedge ACLK);
            ar_now = S_AXI_ARREADY;
            tick();
            n++;
        end
        S_AXI_ARVALID = 1'b0;
        if (!ar_now) fail_now({nm, "_handshake"});
        else chk({nm, "_rvalid_lat"}, 128'(S_AXI_RVALID), 128'(1'b1));
    endtask

    task automatic wait_b(input string nm);
        int n = 0;
        while (exp_b.size() != 0 && n < 40) begin
            @(posedge ACLK);
            n++;
        end
        #1;
        if (exp_b.size() != 0) begin
            fail_now({nm, "_bresp"});
            exp_b.delete();
        end
    endtask

    task automatic wait_r(input string nm);
        int n = 0;
        while (exp_r.size() != 0 && n < 40) begin
            @(posedge ACLK);
            n++;
        end
        #1;
        if (exp_r.size() != 0) begin
            fail_now({nm, "_rresp"});
            exp_r.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    logic [127:0] snap_regs;
    int           snap_pulse[4];
    logic [7:0]   addrs[4];
    logic [31:0]  wvals[4];

    initial begin
        addrs = '{REG_CTRL, REG_SRC_PORT, REG_DST_PORT, REG_DST_IP};
        wvals = '{32'h1, 32'h2, 32'h3, 32'h4};
        ARESETN = 1'b0;
        repeat (3) tick();

        // reset values
        chk("rst_ready", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b111));
        chk("rst_valid", 128'({S_AXI_BVALID, S_AXI_RVALID}), 128'(2'b00));
        chk("rst_resp", 128'({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}), 128'(0));
        chk("rst_regs", reg_out, 128'(0));
        chk("rst_pulse", 128'(wr_pulse), 128'(0));
        ARESETN = 1'b1;
        tick();

        // basic writes then readback
        for (int i = 0; i < 4; i++) begin
            axi_write(addrs[i], wvals[i], 4'hF, RESP_OKAY, "t1_w");
            wait_b("t1_w");
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(addrs[i], wvals[i], RESP_OKAY, "t1_r");
            wait_r("t1_r");
        end
        for (int k = 0; k < 4; k++) chk("t1_pulse_cnt", 128'(pulse_cnt[k]), 128'(1));
        chk("t1_reg_out", reg_out, {32'h4, 32'h3, 32'h2, 32'h1});

        // W leads AW by three cycles
        exp_b.push_back(RESP_OKAY);
        S_AXI_WDATA  = 32'hDEADBEEF;
        S_AXI_WSTRB  = 4'hF;
        S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        tick();
        tick();
        chk("t2_wready_low", 128'(S_AXI_WREADY), 128'(1'b0));
        chk("t2_no_bvalid_early", 128'(S_AXI_BVALID), 128'(1'b0));
        S_AXI_AWADDR  = REG_SRC_PORT[4:0];
        S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        chk("t2_bvalid_lat", 128'(S_AXI_BVALID), 128'(1'b1));
        wait_b("t2");
        chk("t2_reg1", 128'(reg_out[63:32]), 128'(32'hDEADBEEF));
        chk("t2_pulse1", 128'(pulse_cnt[1]), 128'(2));

        // partial strobe merge
        axi_write(REG_CTRL, 32'h11223344, 4'hF, RESP_OKAY, "t3_full");
        wait_b("t3_full");
        axi_write(REG_CTRL, 32'hAABBCCDD, 4'b0101, RESP_OKAY, "t3_part");
        wait_b("t3_part");
        axi_read(REG_CTRL, 32'h11BB33DD, RESP_OKAY, "t3_r");
        wait_r("t3_r");

        // out-of-range access
        snap_regs  = reg_out;
        snap_pulse = pulse_cnt;
        axi_write(8'h10, 32'hFFFFFFFF, 4'hF, RESP_SLVERR, "t4_w");
        wait_b("t4_w");
        axi_read(8'h10, 32'h0, RESP_SLVERR, "t4_r");
        wait_r("t4_r");
        chk("t4_regs_unchanged", reg_out, snap_regs);
        for (int k = 0; k < 4; k++)
            chk("t4_no_pulse", 128'(pulse_cnt[k]), 128'(snap_pulse[k]));

        // BREADY stalled while a read proceeds
        S_AXI_BREADY = 1'b0;
        axi_write(REG_DST_PORT, 32'h000055AA, 4'hF, RESP_OKAY, "t5_w");
        repeat (10) tick();
        chk("t5_bvalid_held", 128'(S_AXI_BVALID), 128'(1'b1));
        chk("t5_wr_readies", 128'({S_AXI_AWREADY, S_AXI_WREADY}), 128'(2'b00));
        chk("t5_bresp_held", 128'(S_AXI_BRESP), 128'(RESP_OKAY));
        axi_read(REG_DST_PORT, 32'h000055AA, RESP_OKAY, "t5_r");
        wait_r("t5_r");
        chk("t5_bvalid_still", 128'(S_AXI_BVALID), 128'(1'b1));
        S_AXI_BREADY = 1'b1;
        wait_b("t5_w");
        chk("t5_pulse2", 128'(pulse_cnt[2]), 128'(2));

        // reset while an address is parked
        S_AXI_AWADDR  = REG_DST_IP[4:0];
        S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        chk("t6_have_addr", 128'({S_AXI_AWREADY, S_AXI_WREADY}), 128'(2'b01));
        ARESETN = 1'b0;
        tick();
        tick();
        ARESETN = 1'b1;
        tick();
        chk("t6_bvalid", 128'(S_AXI_BVALID), 128'(1'b0));
        chk("t6_regs", reg_out, 128'(0));
        chk("t6_readies", 128'({S_AXI_AWREADY, S_AXI_WREADY}), 128'(2'b11));
        // a lone W must not complete the dropped address phase
        S_AXI_WDATA  = 32'h77;
        S_AXI_WSTRB  = 4'hF;
        S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        repeat (5) tick();
        chk("t6_no_resp", 128'(S_AXI_BVALID), 128'(1'b0));
        chk("t6_regs_after_w", reg_out, 128'(0));

        chk("end_b_queue", 128'(exp_b.size()), 128'(0));
        chk("end_r_queue", 128'(exp_r.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
